// File: rtl/switch_port_tx_if.sv
// Host write port and switch ingress port of switch_port_tx, grouped for module connection.
// master = host/switch side, slave = the tx block.
interface switch_port_tx_if;
  logic [31:0] wrData;
  logic        wrValid;
  logic        wrLast;
  logic        wrDest;
  logic        wrReady;
  logic [31:0] portOut;
  logic        outValid;
  logic        sop;
  logic        eop;
  logic        portStall;
  logic        truncErr;
  logic [15:0] pktCount;

  modport master (
    output wrData, wrValid, wrLast, wrDest, portStall,
    input  wrReady, portOut, outValid, sop, eop, truncErr, pktCount
  );

  modport slave (
    input  wrData, wrValid, wrLast, wrDest, portStall,
    output wrReady, portOut, outValid, sop, eop, truncErr, pktCount
  );
endinterface

// File: rtl/switch_port_tx.sv
// Store-and-forward switch ingress transmitter: buffers one packet, then emits header + payload.
// Header appears the cycle after the last word is accepted; portStall freezes all outputs.
module switch_port_tx #(
  parameter int DEPTH = 16
) (
  input logic             clk,
  input logic             reset,
  switch_port_tx_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, HDR, PAY} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;
  logic          dest_q, dest_d;
  logic [31:0]   port_out_q, port_out_d;
  logic          out_valid_q, out_valid_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          trunc_err_q, trunc_err_d;

  logic          wr_ready;
  logic          accept;
  logic          at_full;
  logic          last_acc;
  logic          advance;
  logic          cur_dest;
  logic [15:0]   acc_len;

  assign wr_ready = (state_q == IDLE) || (state_q == LOAD);
  assign accept   = bus.wrValid && wr_ready;
  assign at_full  = (wr_idx_q == IW'(DEPTH - 1));
  // A full buffer closes the packet even without wrLast.
  assign last_acc = accept && (bus.wrLast || at_full);
  assign advance  = !bus.portStall;
  assign cur_dest = (state_q == IDLE) ? bus.wrDest : dest_q;
  assign acc_len  = 16'(wr_idx_q) + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = last_acc ? HDR : LOAD;
      LOAD:    if (last_acc) state_d = HDR;
      HDR:     if (advance) state_d = PAY;
      PAY:     if (advance && eop_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    len_d       = len_q;
    dest_d      = dest_q;
    pkt_cnt_d   = pkt_cnt_q;
    port_out_d  = port_out_q;
    out_valid_d = out_valid_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    trunc_err_d = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          dest_d = cur_dest;
          if (last_acc) begin
            len_d       = acc_len;
            port_out_d  = {acc_len, 8'h00, cur_dest ? 8'h72 : 8'h71};
            out_valid_d = 1'b1;
            sop_d       = 1'b1;
            eop_d       = 1'b0;
            trunc_err_d = !bus.wrLast;
            wr_idx_d    = '0;
            rd_idx_d    = '0;
          end else begin
            wr_idx_d = wr_idx_q + IW'(1);
          end
        end
      end
      HDR: begin
        if (advance) begin
          port_out_d = mem_q[0];
          sop_d      = 1'b0;
          eop_d      = (len_q == 16'd1);
          rd_idx_d   = IW'(1);
        end
      end
      PAY: begin
        if (advance) begin
          if (eop_q) begin
            port_out_d  = '0;
            out_valid_d = 1'b0;
            sop_d       = 1'b0;
            eop_d       = 1'b0;
            pkt_cnt_d   = pkt_cnt_q + 16'd1;
          end else begin
            port_out_d = mem_q[rd_idx_q];
            eop_d      = (16'(rd_idx_q) == len_q - 16'd1);
            rd_idx_d   = rd_idx_q + IW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      len_q       <= '0;
      dest_q      <= 1'b0;
      pkt_cnt_q   <= '0;
      port_out_q  <= '0;
      out_valid_q <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      trunc_err_q <= 1'b0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      len_q       <= len_d;
      dest_q      <= dest_d;
      pkt_cnt_q   <= pkt_cnt_d;
      port_out_q  <= port_out_d;
      out_valid_q <= out_valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      trunc_err_q <= trunc_err_d;
    end
  end

  // Payload storage needs no reset: a discarded packet is never read back.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_idx_q] <= bus.wrData;
  end

  assign bus.wrReady  = wr_ready;
  assign bus.portOut  = port_out_q;
  assign bus.outValid = out_valid_q;
  assign bus.sop      = sop_q;
  assign bus.eop      = eop_q;
  assign bus.truncErr = trunc_err_q;
  assign bus.pktCount = pkt_cnt_q;
endmodule

// File: doc/switch_port_tx.md
SWITCH_PORT_TX -- requirements
Module: switch_port_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 16, payload buffer depth in 32-bit words (max payload per packet).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port wrData  input  32  host payload word.
REQ-005 SHALL have port wrValid  input  1  host word valid.
REQ-006 SHALL have port wrLast  input  1  marks final payload word of packet.
REQ-007 SHALL have port wrDest  input  1  destination switch port (0=A, 1=B), sampled with first word.
REQ-008 SHALL have port wrReady  output  1  block accepts word this cycle.
REQ-009 SHALL have port portOut  output  32  word driven into switch ingress (inA/inB).
REQ-010 SHALL have port outValid  output  1  portOut carries a packet word.
REQ-011 SHALL have port sop  output  1  start of packet, header word only.
REQ-012 SHALL have port eop  output  1  end of packet, last payload word only.
REQ-013 SHALL have port portStall  input  1  switch backpressure for this ingress port.
REQ-014 SHALL have port truncErr  output  1  one-cycle pulse, packet truncated at DEPTH.
REQ-015 SHALL have port pktCount  output  16  packets fully sent since reset.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, HDR, PAY; store-and-forward, one packet at a time.
REQ-017 SHALL accept a word when wrValid && wrReady at a rising edge; wrReady=1 only in IDLE/LOAD, else 0.
REQ-018 IDLE: accepted word SHALL be stored at index 0, wrDest latched, next state LOAD (or HDR if wrLast).
REQ-019 LOAD: each accepted word SHALL be stored at next index; wrLast accepted -> HDR.
REQ-020 Word accepted as the DEPTH-th with wrLast=0 SHALL be treated as last, go HDR, pulse truncErr for one cycle.
REQ-021 Header word SHALL be {len[15:0], 8'h00, code[7:0]}; len = stored payload words (1..DEPTH); code = 8'h71 for dest A, 8'h72 for dest B.
REQ-022 HDR: outputs SHALL be portOut=header, outValid=1, sop=1, eop=0, beginning the cycle after the edge that accepted the last word.
REQ-023 PAY: payload words SHALL be driven in write order with outValid=1, sop=0; eop=1 only on word index len-1.
REQ-024 Output SHALL advance one word per rising edge with portStall=0; with portStall=1 all outputs SHALL hold unchanged.
REQ-025 sop and eop SHALL never be asserted in the same cycle (len>=1).
REQ-026 Edge with eop=1 and portStall=0 SHALL return FSM to IDLE, drive portOut=0, outValid=sop=eop=0, increment pktCount.
REQ-027 pktCount SHALL wrap 16'hFFFF -> 16'h0000.
REQ-028 Idle/LOAD cycles SHALL drive portOut=0, outValid=0, sop=0, eop=0.
REQ-029 All outputs SHALL be registered; no combinational path from portStall or wrValid to any output, except wrReady (state-derived only).
REQ-030 wrValid in HDR/PAY SHALL be ignored; no buffer or state change.

Reset
REQ-031 reset=1 SHALL immediately force IDLE, portOut=0, outValid=0, sop=0, eop=0, truncErr=0, pktCount=0, wrReady=1 after deassert.
REQ-032 Reset mid-LOAD or mid-send SHALL discard the buffered packet; no partial packet resumes after release.

Verification
REQ-033 Write 1 word 32'h45268871, wrDest=0, wrLast=1 -> next cycle header 32'h00010071 sop=1; then 32'h45268871 eop=1; pktCount=1.
REQ-034 Write 3 words, wrDest=1, portStall=0 -> 32'h00030072, w0, w1, w2 on consecutive cycles; eop only on w2; wrReady=0 throughout send.
REQ-035 Same packet, portStall=1 for 3 cycles while on w1 -> w1 held 3 extra cycles, no word lost or duplicated, sop/eop unchanged.
REQ-036 Write 17 words no wrLast (DEPTH=16) -> 16th accepted as last, truncErr 1 cycle, header len 16'h0010, wrReady=0 on 17th.
REQ-037 Assert reset during PAY word 2 of 4 -> outputs 0 same cycle asynchronously, pktCount=0; next packet sends header with correct len.
REQ-038 Preload pktCount to 16'hFFFF via 65535 1-word packets (or force) -> next packet completion gives 16'h0000.
